// File: rtl/controle_robo.sv
// Left-hand wall-following controller for the map/sensor block.
// Issues one-cycle avancar/girar pulses and a held remover, with a settle cycle after each command.
module controle_robo #(
  parameter int REMOVE_TIMEOUT = 15,
  parameter int STEP_W         = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              head,
  input  logic              left,
  input  logic              under,
  input  logic              barrier,
  output logic              avancar,
  output logic              girar,
  output logic              remover,
  output logic [STEP_W-1:0] passos,
  output logic [2:0]        estado,
  output logic              done,
  output logic              stuck
);

  // state    | meaning
  // DECIDE   | sample sensors, pick next action by priority
  // WAIT     | commands low while the map settles
  // TURN_R   | one of three left turns forming a right turn
  // REMOVE   | remover held until barrier clears or timeout
  // DONE     | goal reached, absorbing
  // STUCK    | four right turns without advancing, absorbing
  localparam logic [2:0] S_DECIDE = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_TURN_R = 3'd2;
  localparam logic [2:0] S_REMOVE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_STUCK  = 3'd5;

  localparam logic [3:0] REM_LAST = 4'(REMOVE_TIMEOUT - 1);

  logic [2:0]        state_q, state_d;
  logic [2:0]        estado_q, estado_d;
  logic              avancar_q, avancar_d;
  logic              girar_q, girar_d;
  logic              remover_q, remover_d;
  logic [STEP_W-1:0] passos_q, passos_d;
  logic              done_q, done_d;
  logic              stuck_q, stuck_d;
  logic              turned_left_q, turned_left_d;
  logic [1:0]        turn_cnt_q, turn_cnt_d;
  logic [2:0]        rights_q, rights_d;
  logic [3:0]        rem_cnt_q, rem_cnt_d;

  always_comb begin
    state_d       = state_q;
    avancar_d     = 1'b0;
    girar_d       = 1'b0;
    remover_d     = 1'b0;
    passos_d      = passos_q;
    turned_left_d = turned_left_q;
    turn_cnt_d    = turn_cnt_q;
    rights_d      = rights_q;
    rem_cnt_d     = rem_cnt_q;

    case (state_q)
      S_WAIT: begin
        // turn_cnt of 3 means a full right turn has just completed
        if (turn_cnt_q == 2'd3) begin
          turn_cnt_d = 2'd0;
          rights_d   = rights_q + 3'd1;
          state_d    = (rights_q == 3'd3) ? S_STUCK : S_DECIDE;
        end else if (turn_cnt_q != 2'd0) begin
          state_d = S_TURN_R;
        end else begin
          state_d = S_DECIDE;
        end
      end
      S_DECIDE: begin
        if (under) begin
          state_d = S_DONE;
        end else if (!left && !turned_left_q) begin
          girar_d       = 1'b1;
          turned_left_d = 1'b1;
          state_d       = S_WAIT;
        end else if (!head && barrier) begin
          remover_d = 1'b1;
          rem_cnt_d = 4'd0;
          state_d   = S_REMOVE;
        end else if (!head) begin
          avancar_d     = 1'b1;
          turned_left_d = 1'b0;
          rights_d      = 3'd0;
          if (passos_q != {STEP_W{1'b1}}) passos_d = passos_q + 1'b1;
          state_d       = S_WAIT;
        end else begin
          turn_cnt_d = 2'd0;
          state_d    = S_TURN_R;
        end
      end
      S_TURN_R: begin
        girar_d    = 1'b1;
        turn_cnt_d = turn_cnt_q + 2'd1;
        state_d    = S_WAIT;
      end
      S_REMOVE: begin
        if (!barrier) begin
          state_d = S_WAIT;
        end else if (rem_cnt_q == REM_LAST) begin
          turn_cnt_d = 2'd0;
          state_d    = S_TURN_R;
        end else begin
          remover_d = 1'b1;
          rem_cnt_d = rem_cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_DONE;
      S_STUCK: state_d = S_STUCK;
      default: state_d = S_WAIT;
    endcase

    estado_d = state_d;
    done_d   = (state_d == S_DONE);
    stuck_d  = (state_d == S_STUCK);
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q       <= S_WAIT;
      estado_q      <= 3'd0;
      avancar_q     <= 1'b0;
      girar_q       <= 1'b0;
      remover_q     <= 1'b0;
      passos_q      <= '0;
      done_q        <= 1'b0;
      stuck_q       <= 1'b0;
      turned_left_q <= 1'b0;
      turn_cnt_q    <= 2'd0;
      rights_q      <= 3'd0;
      rem_cnt_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      estado_q      <= estado_d;
      avancar_q     <= avancar_d;
      girar_q       <= girar_d;
      remover_q     <= remover_d;
      passos_q      <= passos_d;
      done_q        <= done_d;
      stuck_q       <= stuck_d;
      turned_left_q <= turned_left_d;
      turn_cnt_q    <= turn_cnt_d;
      rights_q      <= rights_d;
      rem_cnt_q     <= rem_cnt_d;
    end
  end

  assign avancar = avancar_q;
  assign girar   = girar_q;
  assign remover = remover_q;
  assign passos  = passos_q;
  assign estado  = estado_q;
  assign done    = done_q;
  assign stuck   = stuck_q;

endmodule

// File: tb/tb_controle_robo.sv
// Bench for controle_robo: directed scenarios plus random sensor episodes,
// checked against a procedural model of the wall-following policy.
module tb_controle_robo;

  localparam int TIMEOUT = 15;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       head = 1'b0, left = 1'b1, under = 1'b0, barrier = 1'b0;
  logic       avancar, girar, remover, done, stuck;
  logic [7:0] passos;
  logic [2:0] estado;

  int errors = 0;
  int checks = 0;

  // model of the robot's memory
  int m_passos;
  bit m_tl;
  int m_rights;
  bit ended;
  bit rnd_mode;

  controle_robo #(.REMOVE_TIMEOUT(TIMEOUT), .STEP_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .head(head), .left(left), .under(under),
    .barrier(barrier), .avancar(avancar), .girar(girar), .remover(remover),
    .passos(passos), .estado(estado), .done(done), .stuck(stuck)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic exp_out(input string tag, input bit a, input bit g, input bit r, input int est);
    chk({tag, "_cmd"}, 32'({avancar, girar, remover}), 32'({a, g, r}));
    chk({tag, "_estado"}, 32'(estado), 32'(est));
    chk({tag, "_flags"}, 32'({done, stuck}), 32'({est == 4, est == 5}));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // sensors are irrelevant outside DECIDE; random mode proves they are ignored
  task automatic scramble();
    if (rnd_mode) begin
      head  = 1'($urandom % 2);
      left  = 1'($urandom % 2);
      under = 1'($urandom % 2);
      barrier = 1'($urandom % 2);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #3;
    chk("rst_cmd", 32'({avancar, girar, remover}), 32'd0);
    chk("rst_passos", 32'(passos), 32'd0);
    chk("rst_estado", 32'(estado), 32'd0);
    chk("rst_flags", 32'({done, stuck}), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    m_passos = 0; m_tl = 0; m_rights = 0; ended = 0;
    tick();
    exp_out("rst_rel", 0, 0, 0, 0);
  endtask

  // right turn: three left-turn pulses, each followed by a quiet cycle
  task automatic right_turn();
    for (int i = 0; i < 3; i++) begin
      scramble();
      tick();
      exp_out("rturn_pulse", 0, 1, 0, 1);
      scramble();
      tick();
      if (i < 2) begin
        exp_out("rturn_gap", 0, 0, 0, 2);
      end else begin
        m_rights++;
        if (m_rights == 4) begin
          exp_out("stuck_entry", 0, 0, 0, 5);
          ended = 1;
        end else begin
          exp_out("rturn_end", 0, 0, 0, 0);
        end
      end
    end
  endtask

  // one decision, starting with the DUT in DECIDE; nbar = REMOVE cycles barrier stays 1
  task automatic step(input bit h, input bit l, input bit u, input bit b, input int nbar);
    if (ended) return;
    head = h; left = l; under = u; barrier = b;
    tick();
    if (u) begin
      exp_out("goal", 0, 0, 0, 4);
      ended = 1;
    end else if (!l && !m_tl) begin
      exp_out("left_turn", 0, 1, 0, 1);
      m_tl = 1;
      scramble();
      tick();
      exp_out("left_gap", 0, 0, 0, 0);
    end else if (!h && b) begin
      exp_out("rem_start", 0, 0, 1, 3);
      for (int k = 0; k < TIMEOUT; k++) begin
        bit bv;
        bv = (k < nbar);
        scramble();
        barrier = bv;
        tick();
        if (!bv) begin
          exp_out("rem_clear", 0, 0, 0, 1);
          scramble();
          tick();
          exp_out("rem_back", 0, 0, 0, 0);
          break;
        end else if (k == TIMEOUT - 1) begin
          exp_out("rem_timeout", 0, 0, 0, 2);
          right_turn();
        end else begin
          exp_out("rem_hold", 0, 0, 1, 3);
        end
      end
    end else if (!h) begin
      m_passos = (m_passos < 255) ? m_passos + 1 : 255;
      m_tl = 0;
      m_rights = 0;
      exp_out("advance", 1, 0, 0, 1);
      chk("passos", 32'(passos), 32'(m_passos));
      scramble();
      tick();
      exp_out("adv_gap", 0, 0, 0, 0);
    end else begin
      exp_out("wall_ahead", 0, 0, 0, 2);
      right_turn();
    end
  endtask

  initial begin
    rnd_mode = 0;
    do_reset();

    // straight corridor
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0);
    chk("corridor_passos", 32'(passos), 32'd4);

    // left opening: turn, advance although left still open, then turn again
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("opening_passos", 32'(passos), 32'd5);
    step(0, 0, 0, 0, 0);

    // dead end then continue
    step(1, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // enclosed
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0);
    chk("enclosed_ended", 32'(ended), 32'd1);
    for (int i = 0; i < 3; i++) begin
      head = 1'($urandom % 2); left = 1'($urandom % 2);
      tick();
      exp_out("stuck_hold", 0, 0, 0, 5);
    end

    // trash, then timeout, then goal
    do_reset();
    step(0, 1, 0, 1, 3);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 99);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      under = 1'b0; head = 1'b0;
      tick();
      exp_out("done_hold", 0, 0, 0, 4);
    end

    // reset while removing
    do_reset();
    step(0, 1, 0, 0, 0);
    head = 0; left = 1; barrier = 1;
    tick();
    exp_out("midrem_a", 0, 0, 1, 3);
    tick();
    exp_out("midrem_b", 0, 0, 1, 3);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrem_remover", 32'(remover), 32'd0);
    chk("midrem_passos", 32'(passos), 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    m_passos = 0; m_tl = 0; m_rights = 0; ended = 0;
    barrier = 0;
    tick();
    exp_out("midrem_decide", 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);

    // step counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) step(0, 1, 0, 0, 0);
    chk("passos_sat", 32'(passos), 32'd255);

    // random episodes
    rnd_mode = 1;
    for (int ep = 0; ep < 12; ep++) begin
      do_reset();
      for (int n = 0; n < 60 && !ended; n++) begin
        step(1'($urandom % 2), 1'($urandom % 4 != 0), 1'($urandom % 30 == 0),
             1'($urandom % 3 == 0), int'($urandom_range(0, 18)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/controle_robo.md
Name: controle_robo

Overview:
- Autonomous robot controller that drives the map/sensor block using a left-hand wall-following policy.
- Consumes the map's head, left, under and barrier sensor flags and produces one-cycle avancar/girar commands plus a held remover command.
- Clocked by the map's robot clock (ClockRobo in the top level), so commands and sensor updates share one clock domain.

Parameters:
- REMOVE_TIMEOUT, 15, cycles remover may be held before the barrier is treated as a wall (range 1..15).
- STEP_W, 8, width of the step counter passos.

Ports:
- Clock  in  1  robot clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- head  in  1  1 = wall or map edge directly ahead.
- left  in  1  1 = wall or map edge directly to the robot's left.
- under  in  1  1 = robot is standing on the black (goal) cell.
- barrier  in  1  1 = trash item in the cell ahead.
- avancar  out  1  advance-one-cell command; single-cycle pulse.
- girar  out  1  rotate 90 degrees counter-clockwise (left turn); single-cycle pulse.
- remover  out  1  remove-trash command; held high across consecutive cycles.
- passos  out  STEP_W  count of avancar pulses issued; saturates at all-ones.
- estado  out  3  current FSM state code, for LEDs.
- done  out  1  1 while in state DONE.
- stuck  out  1  1 while in state STUCK.

Behaviour:
- All outputs are registered. Reset forces every output to 0, state to WAIT, all internal counters and flags to 0, immediately (asynchronously), including mid-command.
- State codes: DECIDE=0, WAIT=1, TURN_R=2, REMOVE=3, DONE=4, STUCK=5.
- Command timing: a command register is set at the edge leaving DECIDE; the map acts on it at the next edge. The FSM then spends one WAIT cycle while the sensors settle. Each avancar/girar is therefore high for exactly 1 cycle, followed by at least 1 cycle with all commands low.
- WAIT: all commands 0; the next edge goes to DECIDE, or back to TURN_R if a right turn is still in progress.
- DECIDE samples the inputs and applies the first matching rule, in priority order:
  1. under=1 -> DONE, no command.
  2. left=0 and flag turned_left=0 -> pulse girar, set turned_left=1, -> WAIT.
  3. head=0 and barrier=1 -> assert remover, clear rem_cnt, -> REMOVE.
  4. head=0 -> pulse avancar, clear turned_left and rights, increment passos (saturating), -> WAIT.
  5. head=1 -> TURN_R with turn_cnt=0.
- The turned_left flag prevents re-turning left before advancing into the opening just found.
- TURN_R (right turn = 3 left turns):
  - Each visit pulses girar, increments turn_cnt, then goes to WAIT.
  - After the 3rd pulse's WAIT, increment rights and return to DECIDE.
  - If rights reaches 4 with no avancar in between (robot enclosed), go to STUCK instead.
- REMOVE:
  - remover stays high; rem_cnt increments each cycle.
  - When barrier is sampled 0: drop remover, go to WAIT, then DECIDE, which will normally advance. One extra remover-high cycle after the map clears the barrier is expected and harmless.
  - If rem_cnt reaches REMOVE_TIMEOUT with barrier still 1: drop remover, go to TURN_R (treat as wall).
  - under rising during REMOVE is ignored until the next DECIDE.
- DONE and STUCK: absorbing states, all commands 0; only Reset exits them.
- Invariant: at most one of avancar/girar/remover is high in any cycle.
- Sensor values are used only in DECIDE, and in REMOVE for barrier; changes during WAIT are ignored.

Test Plan:
- Straight corridor: left=1, head=0, barrier=0, under=0 held. Expect avancar on alternating cycles (1,0,1,0...), passos increments to 4 after 8 cycles, girar never high.
- Left opening: left=0 in first DECIDE. Expect a girar pulse, then WAIT, then avancar in the next DECIDE even though left is still 0; turned_left clears after avancar.
- Dead end: head=1, left=1. Expect 3 girar pulses, each separated by one WAIT cycle, then DECIDE with estado=0.
- Enclosed: head=1, left=1 held. Expect 12 girar pulses, then stuck=1, estado=5, no further commands.
- Trash: head=0, barrier=1 until remover has been high for 3 cycles, then barrier=0. Expect remover high for 4 cycles, then WAIT, then one avancar pulse.
- Timeout: barrier held 1. Expect remover high for 15 cycles, then 3 girar pulses.
- Goal: under=1 at the first DECIDE. Expect done=1, estado=4, no commands.
- Reset mid-REMOVE: asserting Reset drops remover and passos to 0 immediately; after release, one WAIT cycle, then DECIDE.
